// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               (IF) and load/store (LS) paths. Only one transaction is in
//               flight at a time. Each response is routed back to the
//               requester that issued it.
//               Optional build macro MEM_ARB_RR_EN: round-robin arbitration
//               on contention. If it is undefined, LS has fixed priority
//               over IF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  // instruction-fetch requester
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  // load/store requester
  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [DATA_WIDTH/8-1:0] ls_be_i,
  input  logic [ADDR_WIDTH-1:0]   ls_addr_i,
  input  logic [DATA_WIDTH-1:0]   ls_wdata_i,
  output logic                    ls_gnt_o,
  output logic                    ls_rvalid_o,
  output logic [DATA_WIDTH-1:0]   ls_rdata_o,
  // shared memory port
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int c_BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_t;

  state_t r_state;
  owner_t r_owner;

  logic w_idle;
  logic w_ls_win;
  logic w_if_win;

`ifdef MEM_ARB_RR_EN
  owner_t r_last_served;

  // On contention, LS wins only when IF was the most recently served requester
  assign w_ls_win = ls_req_i & (~if_req_i | (r_last_served == OWNER_IF));
`else
  // Fixed priority: LS always beats IF
  assign w_ls_win = ls_req_i;
`endif

  assign w_if_win = if_req_i & ~w_ls_win;
  assign w_idle   = (r_state == IDLE);

  // Grants are combinational and are only issued from IDLE outside reset
  assign ls_gnt_o = w_idle & ~reset & w_ls_win;
  assign if_gnt_o = w_idle & ~reset & w_if_win;

`ifdef MEM_ARB_RR_EN
  // Record which requester took the most recent grant
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_served <= OWNER_LS;
    end else if (w_idle && (w_ls_win || w_if_win)) begin
      r_last_served <= w_ls_win ? OWNER_LS : OWNER_IF;
    end
  end
`endif

  // Transaction FSM: latch the command, present it to memory, route the response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= OWNER_IF;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rvalid_o <= 1'b0;
      if_rdata_o  <= '0;
      ls_rvalid_o <= 1'b0;
      ls_rdata_o  <= '0;
    end else begin
      // Response strobes are single-cycle pulses
      if_rvalid_o <= 1'b0;
      ls_rvalid_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ls_win) begin
            r_owner     <= OWNER_LS;
            mem_req_o   <= 1'b1;
            mem_we_o    <= ls_we_i;
            mem_be_o    <= ls_be_i;
            mem_addr_o  <= ls_addr_i;
            mem_wdata_o <= ls_wdata_i;
            r_state     <= ISSUE;
          end else if (w_if_win) begin
            // Fetches are always full-word reads
            r_owner     <= OWNER_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_be_o    <= {c_BE_WIDTH{1'b1}};
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (r_owner == OWNER_LS) begin
              ls_rvalid_o <= 1'b1;
              // A store is acknowledged with zero data
              ls_rdata_o  <= mem_we_o ? '0 : mem_rdata_i;
            end else begin
              if_rvalid_o <= 1'b1;
              if_rdata_o  <= mem_rdata_i;
            end
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed scenarios
//               and a randomized phase are checked against a transaction-level
//               model of arbitration, command forwarding and response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  // model state: who was served last, last data seen by each requester,
  // and a response expected at the next check point (0 none, 1 IF, 2 LS)
  bit          m_last_ls;
  logic [31:0] m_if_rdata;
  logic [31:0] m_ls_rdata;
  int          pend_rv;
  logic [31:0] pend_data;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .ls_req_i     (ls_req_i),
    .ls_we_i      (ls_we_i),
    .ls_be_i      (ls_be_i),
    .ls_addr_i    (ls_addr_i),
    .ls_wdata_i   (ls_wdata_i),
    .ls_gnt_o     (ls_gnt_o),
    .ls_rvalid_o  (ls_rvalid_o),
    .ls_rdata_o   (ls_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Compare response outputs with the model and retire any pending response
  task automatic chk_rsp();
    if (pend_rv == 1) m_if_rdata = pend_data;
    if (pend_rv == 2) m_ls_rdata = pend_data;
    chk("if_rvalid", if_rvalid_o, pend_rv == 1);
    chk("ls_rvalid", ls_rvalid_o, pend_rv == 2);
    chk("if_rdata",  if_rdata_o,  m_if_rdata);
    chk("ls_rdata",  ls_rdata_o,  m_ls_rdata);
    pend_rv = 0;
  endtask

  // One idle cycle with no requests outstanding
  task automatic idle();
    @(negedge clock);
    chk_rsp();
    chk("idle_if_gnt", if_gnt_o, 1'b0);
    chk("idle_ls_gnt", ls_gnt_o, 1'b0);
    chk("idle_mem_req", mem_req_o, 1'b0);
    cyc();
  endtask

  // One full transaction starting in IDLE with requests already driven.
  // gd: cycles of mem_gnt_i low, rd: cycles of response delay.
  task automatic txn(input int gd, input int rd, input bit drop, input logic [31:0] data);
    bit          w_ls;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
`ifdef MEM_ARB_RR_EN
    if (ls_req_i && if_req_i) w_ls = !m_last_ls;
    else                      w_ls = ls_req_i;
`else
    w_ls = ls_req_i;
`endif
    if (w_ls) begin
      e_we = ls_we_i; e_be = ls_be_i; e_addr = ls_addr_i; e_wdata = ls_wdata_i;
    end else begin
      e_we = 1'b0; e_be = 4'hF; e_addr = if_addr_i; e_wdata = 32'h0;
    end
    @(negedge clock);
    chk_rsp();
    chk("if_gnt", if_gnt_o, !w_ls);
    chk("ls_gnt", ls_gnt_o, w_ls);
    m_last_ls = w_ls;
    cyc();
    if (drop) begin
      if (w_ls) ls_req_i = 1'b0;
      else      if_req_i = 1'b0;
    end
    mem_gnt_i = (gd == 0);
    @(negedge clock);
    chk_rsp();
    chk("mem_req",   mem_req_o,   1'b1);
    chk("mem_we",    mem_we_o,    e_we);
    chk("mem_be",    mem_be_o,    e_be);
    chk("mem_addr",  mem_addr_o,  e_addr);
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("busy_if_gnt", if_gnt_o, 1'b0);
    chk("busy_ls_gnt", ls_gnt_o, 1'b0);
    for (int k = 0; k < gd; k++) begin
      cyc();
      mem_gnt_i = (k == gd - 1);
      @(negedge clock);
      chk("stall_mem_req",  mem_req_o,  1'b1);
      chk("stall_mem_addr", mem_addr_o, e_addr);
      chk("stall_mem_we",   mem_we_o,   e_we);
      chk("stall_if_gnt",   if_gnt_o,   1'b0);
      chk("stall_ls_gnt",   ls_gnt_o,   1'b0);
    end
    for (int k = 0; k <= rd; k++) begin
      cyc();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = (k == rd);
      mem_rdata_i  = (k == rd) ? data : $urandom;
      @(negedge clock);
      chk_rsp();
      chk("wait_mem_req", mem_req_o, 1'b0);
      chk("wait_if_gnt",  if_gnt_o,  1'b0);
      chk("wait_ls_gnt",  ls_gnt_o,  1'b0);
    end
    cyc();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    pend_rv   = w_ls ? 2 : 1;
    pend_data = (w_ls && e_we) ? 32'h0 : data;
  endtask

  initial begin
    reset = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_be_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    m_last_ls = 1'b1; m_if_rdata = '0; m_ls_rdata = '0; pend_rv = 0; pend_data = '0;

    // reset state
    @(negedge clock);
    chk("rst_mem_req",   mem_req_o,   1'b0);
    chk("rst_mem_we",    mem_we_o,    1'b0);
    chk("rst_mem_be",    mem_be_o,    4'h0);
    chk("rst_mem_addr",  mem_addr_o,  32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk_rsp();
    cyc();
    cyc();
    reset = 1'b0;
    idle();

    // single fetch
    if_req_i = 1'b1; if_addr_i = 32'h10;
    txn(0, 0, 1'b1, 32'h00500093);
    idle();

    // store
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_be_i = 4'h3;
    ls_addr_i = 32'h200; ls_wdata_i = 32'hDEADBEEF;
    txn(0, 0, 1'b1, $urandom);
    idle();

    // contention with both requests held for four transactions
    if_req_i = 1'b1; if_addr_i = 32'h40;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h300; ls_wdata_i = 32'h0;
    for (int n = 0; n < 4; n++) txn(0, 0, 1'b0, $urandom);
    if_req_i = 1'b0; ls_req_i = 1'b0;
    idle();
    idle();

    // memory stall with the other requester waiting, then serve it
    if_req_i = 1'b1; if_addr_i = 32'h80;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'h5; ls_addr_i = 32'h404; ls_wdata_i = 32'h1234;
    txn(3, 2, 1'b1, $urandom);
    txn(0, 0, 1'b1, $urandom);
    idle();

    // reset while waiting for the memory response
    if_req_i = 1'b1; if_addr_i = 32'hC0;
    @(negedge clock);
    chk("pre_rst_if_gnt", if_gnt_o, 1'b1);
    chk_rsp();
    cyc();
    if_req_i = 1'b0; mem_gnt_i = 1'b1;
    cyc();
    mem_gnt_i = 1'b0;
    reset = 1'b1;
    m_last_ls = 1'b1; m_if_rdata = '0; m_ls_rdata = '0; pend_rv = 0;
    @(negedge clock);
    chk("rstw_mem_req",   mem_req_o,   1'b0);
    chk("rstw_mem_be",    mem_be_o,    4'h0);
    chk("rstw_mem_addr",  mem_addr_o,  32'h0);
    chk_rsp();
    cyc();
    reset = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD1234;
    @(negedge clock);
    chk_rsp();
    cyc();
    mem_rvalid_i = 1'b0;
    idle();
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_be_i = 4'hF; ls_addr_i = 32'h500;
    txn(0, 1, 1'b1, $urandom);
    idle();

    // randomized traffic; a pending requester holds its command until granted
    for (int n = 0; n < 30; n++) begin
      if (!if_req_i && ($urandom_range(0, 1) == 1)) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      if (!ls_req_i && ($urandom_range(0, 1) == 1)) begin
        ls_req_i = 1'b1; ls_we_i = 1'($urandom); ls_be_i = 4'($urandom);
        ls_addr_i = $urandom; ls_wdata_i = $urandom;
      end
      if (!if_req_i && !ls_req_i) begin
        if_req_i = 1'b1; if_addr_i = $urandom;
      end
      txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1, $urandom);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported memory between the CPU's instruction-fetch path and its load/store path. It accepts requests from both sides and serialises them into one transaction at a time on the memory port. It routes each response back to the requester that issued it. It sits between the CPU core and the unified program/data memory, replacing separate instruction and data memories.

## Interface
- ADDR_WIDTH, 32, byte address width for all address ports
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held with address until if_gnt_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_gnt_o  out  1  fetch command accepted this cycle
- if_rvalid_o  out  1  fetch data valid, one-cycle pulse
- if_rdata_o  out  DATA_WIDTH  fetched instruction
- ls_req_i  in  1  load/store request; held with command until ls_gnt_o
- ls_we_i  in  1  1 = store, 0 = load
- ls_be_i  in  DATA_WIDTH/8  store byte enables
- ls_addr_i  in  ADDR_WIDTH  load/store address
- ls_wdata_i  in  DATA_WIDTH  store data
- ls_gnt_o  out  1  load/store command accepted this cycle
- ls_rvalid_o  out  1  load data or store acknowledge, one-cycle pulse
- ls_rdata_o  out  DATA_WIDTH  load data; 0 for stores
- mem_req_o  out  1  memory command valid
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1 / DATA_WIDTH/8 / ADDR_WIDTH / DATA_WIDTH  memory command fields
- mem_gnt_i  in  1  memory accepted command
- mem_rvalid_i  in  1  memory response valid, one cycle
- mem_rdata_i  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE. At most one outstanding transaction.
- IDLE: if any req_i is high, select a winner, then:
  - assert the winner's gnt_o combinationally in the same cycle;
  - latch its command into the mem_* output registers and latch owner (IF or LS);
  - go to ISSUE.
- Fetch commands are driven as we=0, be=all ones, wdata=0.
- Load commands are forwarded with ls_be_i unchanged.
- ISSUE: mem_req_o=1, with the command held stable. On mem_gnt_i, drop mem_req_o and go to WAIT.
- WAIT: on mem_rvalid_i, register mem_rdata_i into the owner's rdata_o (0 if store) and pulse the owner's rvalid_o next cycle. Go to IDLE.
- The non-owner's rvalid_o stays 0, and its rdata_o holds its last value.
- mem_rvalid_i outside WAIT is ignored. Memory must not respond in the same cycle as mem_gnt_i.
- gnt_o is never asserted outside IDLE. A requester keeping req_i high simply waits.
- Default arbitration: LS has fixed priority over IF when both request in the same IDLE cycle.

## Timing
- Reset values: all gnt_o, rvalid_o, rdata_o and mem_* outputs are 0; owner=IF; last_served=LS.
- Reset mid-transaction: return immediately to IDLE with all outputs 0. The discarded transaction produces no rvalid, and any late mem_rvalid_i is ignored.
- Minimum latency:
  - cycle 0: req and gnt;
  - cycle 1: mem_req_o, with mem_gnt_i;
  - cycle 2: mem_rvalid_i;
  - cycle 3: requester rvalid_o, with the FSM back in IDLE.
- A new grant is possible in cycle 3, so peak throughput is one transaction per 3 cycles.
- Each cycle of mem_gnt_i low extends ISSUE by one cycle. Each cycle of response delay extends WAIT by one cycle.
- In cycle 3, rvalid_o to one requester and gnt_o to the same or the other requester may coincide.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On simultaneous requests in IDLE, grant the requester other than last_served. last_served updates at every grant. Since last_served resets to LS, the first contention goes to IF.
- MEM_ARB_RR_EN undefined: fixed LS-over-IF priority, and the last_served register is not present. IF starves while LS requests continuously.

## Test plan
- Single fetch: if_req_i=1, if_addr_i=0x10, mem_gnt_i=1 in cycle 1, mem_rvalid_i=1 with rdata 0x00500093 in cycle 2 -> if_gnt_o cycle 0; mem_addr_o=0x10, we=0, be=0xF in cycle 1; if_rvalid_o=1 with 0x00500093 in cycle 3; ls_rvalid_o=0 throughout.
- Store: ls_we_i=1, ls_be_i=0x3, ls_addr_i=0x200, ls_wdata_i=0xDEADBEEF -> mem_* carry those values; ls_rvalid_o pulses with ls_rdata_o=0; if_rvalid_o=0.
- Contention, macro off: both requests held high for 4 transactions -> LS served all 4, if_gnt_o never asserted.
- Contention, MEM_ARB_RR_EN on: both requests held high -> grant order IF, LS, IF, LS, each grant 3 cycles apart with zero-wait memory.
- Stall: mem_gnt_i low for 3 cycles, then response delayed 2 cycles -> mem_req_o and command stable for 4 cycles; no gnt_o during the transaction; rvalid arrives in cycle 7.
- Reset in WAIT: assert reset, then drive mem_rvalid_i=1 after release -> all outputs 0, no rvalid_o pulse, FSM in IDLE granting the next request normally.
